regfile_scoreboard: RTL and testbench

//  Sequences the register file: tracks in-flight destination registers,

---
 rtl/regfile_scoreboard.sv | 122 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register scoreboard, hazard stall and RF write-port arbiter
//
// Tracks which destination registers have a result in flight, stalls issue
// on RAW/WAW hazards against them, and arbitrates the single register-file
// write port between ALU and load-unit writeback. The RF write controls are
// driven from registers, so a granted writeback reaches the RF one edge after
// the handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_*                  decode/issue request; issue_stall is combinational
//   alu_wb_valid/rd/data     ALU writeback request; alu_wb_ready is the grant
//   mem_wb_valid/rd/data     load writeback request; mem_wb_ready is the grant
//   rf_write_enable/rd/data  registered write controls to the register file
//   pending                  in-flight destination bitmap (bit 0 always 0)
//   wb_err                   sticky flag: writeback hit a non-pending register
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int RR     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic [REG_AW-1:0]        issue_rs1,
  input  logic [REG_AW-1:0]        issue_rs2,
  input  logic                     issue_use_rs1,
  input  logic                     issue_use_rs2,
  output logic                     issue_stall,
  input  logic                     alu_wb_valid,
  input  logic [REG_AW-1:0]        alu_wb_rd,
  input  logic [XLEN-1:0]          alu_wb_data,
  output logic                     alu_wb_ready,
  input  logic                     mem_wb_valid,
  input  logic [REG_AW-1:0]        mem_wb_rd,
  input  logic [XLEN-1:0]          mem_wb_data,
  output logic                     mem_wb_ready,
  output logic                     rf_write_enable,
  output logic [REG_AW-1:0]        rf_rd,
  output logic [XLEN-1:0]          rf_write_data,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic                     wb_err
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_next;
  logic              last_grant_mem;
  logic              grant_alu;
  logic              grant_mem;
  logic              wb_fire;
  logic              accept;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  assign pending = pending_q;

  // pending[0] is never set, so rd=0 / rs=0 can never cause a stall.
  assign issue_stall = issue_valid &
                       ((issue_use_rs1 & pending_q[issue_rs1]) |
                        (issue_use_rs2 & pending_q[issue_rs2]) |
                        pending_q[issue_rd]);
  assign accept = issue_valid & ~issue_stall;

  // One grant per cycle. The loser sees ready low and must hold its request.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_wb_valid && mem_wb_valid) begin
      if (RR != 0) begin
        if (last_grant_mem) grant_alu = 1'b1;
        else                grant_mem = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (alu_wb_valid) begin
      grant_alu = 1'b1;
    end else if (mem_wb_valid) begin
      grant_mem = 1'b1;
    end
  end

  assign alu_wb_ready = grant_alu;
  assign mem_wb_ready = grant_mem;
  assign wb_fire      = grant_alu | grant_mem;
  assign win_rd       = grant_mem ? mem_wb_rd   : alu_wb_rd;
  assign win_data     = grant_mem ? mem_wb_data : alu_wb_data;

  // Clear happens on the edge the RF actually writes; a same-index set from
  // an accepted issue is applied afterwards so it wins.
  always_comb begin
    pending_next = pending_q;
    if (rf_write_enable) pending_next[rf_rd] = 1'b0;
    if (accept && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q       <= '0;
      last_grant_mem  <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_rd           <= '0;
      rf_write_data   <= '0;
      wb_err          <= 1'b0;
    end else begin
      pending_q <= pending_next;
      if (alu_wb_valid && mem_wb_valid) last_grant_mem <= grant_mem;
      if (wb_fire) begin
        rf_rd           <= win_rd;
        rf_write_data   <= win_data;
        rf_write_enable <= (win_rd != '0);
        if ((win_rd != '0) && !pending_q[win_rd]) wb_err <= 1'b1;
      end else begin
        rf_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic              issue_use_rs1, issue_use_rs2;
  logic              issue_stall;
  logic              alu_wb_valid;
  logic [REG_AW-1:0] alu_wb_rd;
  logic [XLEN-1:0]   alu_wb_data;
  logic              alu_wb_ready;
  logic              mem_wb_valid;
  logic [REG_AW-1:0] mem_wb_rd;
  logic [XLEN-1:0]   mem_wb_data;
  logic              mem_wb_ready;
  logic              rf_write_enable;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_write_data;
  logic [31:0]       pending;
  logic              wb_err;

  regfile_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .RR(1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
    .rf_write_enable(rf_write_enable), .rf_rd(rf_rd),
    .rf_write_data(rf_write_data), .pending(pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic model_last_mem = 1'b0;
  bit   ga, gm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every RF write seen must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rf_rd), 64'hdead);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", 64'(rf_rd), 64'(e.rd));
        check("wr_data", 64'(rf_write_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called just after a posedge; presents writeback requests for one cycle,
  // checks the grant against the bench arbitration model, returns after the
  // handshake edge.
  task automatic drive_wb(input bit av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                          input bit mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                          output bit o_ga, output bit o_gm);
    bit ea, em;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
    mem_wb_valid = mv; mem_wb_rd = mrd; mem_wb_data = md;
    if (av && mv) begin
      em = !model_last_mem;
      ea = !em;
      model_last_mem = em;
    end else begin
      ea = av;
      em = mv;
    end
    @(negedge clk);
    check("alu_ready", 64'(alu_wb_ready), 64'(ea));
    check("mem_ready", 64'(mem_wb_ready), 64'(em));
    if (ea && ard != 0) exp_q.push_back('{rd: ard, data: ad});
    if (em && mrd != 0) exp_q.push_back('{rd: mrd, data: md});
    o_ga = ea;
    o_gm = em;
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd, input bit exp_stall);
    issue_valid = 1'b1; issue_rd = rd; issue_rs1 = '0; issue_rs2 = '0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
    @(negedge clk);
    check("issue_stall", 64'(issue_stall), 64'(exp_stall));
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  initial begin
    int ai, mi;
    bit exp_gm[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_we", 64'(rf_write_enable), 64'd0);
    check("rst_rd", 64'(rf_rd), 64'd0);
    check("rst_data", 64'(rf_write_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    check("rst_stall", 64'(issue_stall), 64'd0);
    @(posedge clk); #1;

    // 1: issue rd=5
    issue(5'd5, 1'b0);
    @(negedge clk);
    check("pending_after_issue5", 64'(pending), 64'h20);
    @(posedge clk); #1;

    // 2: RAW stall on x5, then ALU writeback clears it
    issue_valid = 1'b1; issue_rd = 0; issue_rs1 = 5; issue_use_rs1 = 1'b1;
    @(negedge clk);
    check("raw_stall", 64'(issue_stall), 64'd1);
    @(posedge clk); #1;
    drive_wb(1, 5'd5, 32'hAB, 0, 5'd0, 32'h0, ga, gm);
    @(negedge clk);
    check("after_e0_we", 64'(rf_write_enable), 64'd1);
    check("after_e0_pending", 64'(pending), 64'h20);
    check("after_e0_stall", 64'(issue_stall), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_e1_pending", 64'(pending), 64'd0);
    check("after_e1_stall", 64'(issue_stall), 64'd0);
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_use_rs1 = 1'b0;

    // WAW stall on a pending destination
    issue(5'd9, 1'b0);
    issue(5'd9, 1'b1);
    drive_wb(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, ga, gm);

    // 3: round-robin contention, rd 1..4 pending
    issue(5'd1, 1'b0);
    issue(5'd2, 1'b0);
    issue(5'd3, 1'b0);
    issue(5'd4, 1'b0);
    @(negedge clk);
    check("pending_1to4", 64'(pending), 64'h1E);
    @(posedge clk); #1;
    ai = 1; mi = 3;
    for (int c = 0; c < 4; c++) begin
      drive_wb(ai <= 2, 5'(ai), 32'h100 + ai, mi <= 4, 5'(mi), 32'h200 + mi, ga, gm);
      check("rr_grant_mem", 64'(gm), 64'(exp_gm[c]));
      if (ga) ai++;
      if (gm) mi++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_all_done", 64'({ai[7:0], mi[7:0]}), 64'h0305);
    check("rr_pending_clear", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // 4: rd=0 writeback completes without an RF write
    drive_wb(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF, ga, gm);
    @(negedge clk);
    check("rd0_no_we", 64'(rf_write_enable), 64'd0);
    check("rd0_no_err", 64'(wb_err), 64'd0);
    @(posedge clk); #1;

    // 5: writeback to non-pending x7 sets sticky wb_err
    drive_wb(1, 5'd7, 32'h77, 0, 5'd0, 32'h0, ga, gm);
    @(negedge clk);
    check("wb_err_set", 64'(wb_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("wb_err_sticky", 64'(wb_err), 64'd1);
    check("wb_err_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // 6: reset the cycle after a handshake on x3
    issue(5'd3, 1'b0);
    drive_wb(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, ga, gm);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 64'(rf_write_enable), 64'd0);
    check("rst_mid_pending", 64'(pending), 64'd0);
    check("rst_mid_err", 64'(wb_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
